tl45_wb_arbiter: RTL

Two-master, one-slave Wishbone (pipelined) bus arbiter for the tl45 core. It shares the single memory bus between the instruction prefetch unit (port A) and the memory/load-store stage (port B). It registers a grant and holds it for the whole bus cycle of the owner. It forwards the owner's request signals to the slave and routes ack/err/stall back only to the owner. A watchdog ends any bus cycle that goes unacknowledged for too long.

---
 rtl/tl45_wb_arbiter.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/tl45_wb_arbiter.sv
// Two-master, one-slave pipelined Wishbone arbiter: prefetch (A) and memory stage (B).
// Round-robin on ties, grant held for the owner's whole cycle, watchdog aborts hung cycles.
module tl45_wb_arbiter #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        i_clk,
   input  logic        i_reset_n,
   input  logic        i_a_cyc,
   input  logic        i_a_stb,
   input  logic        i_a_we,
   input  logic [29:0] i_a_addr,
   input  logic [31:0] i_a_data,
   input  logic [3:0]  i_a_sel,
   output logic        o_a_ack,
   output logic        o_a_err,
   output logic        o_a_stall,
   output logic [31:0] o_a_data,
   input  logic        i_b_cyc,
   input  logic        i_b_stb,
   input  logic        i_b_we,
   input  logic [29:0] i_b_addr,
   input  logic [31:0] i_b_data,
   input  logic [3:0]  i_b_sel,
   output logic        o_b_ack,
   output logic        o_b_err,
   output logic        o_b_stall,
   output logic [31:0] o_b_data,
   output logic        o_wb_cyc,
   output logic        o_wb_stb,
   output logic        o_wb_we,
   output logic [29:0] o_wb_addr,
   output logic [31:0] o_wb_data,
   output logic [3:0]  o_wb_sel,
   input  logic        i_wb_ack,
   input  logic        i_wb_stall,
   input  logic        i_wb_err,
   input  logic [31:0] i_wb_data
);

   localparam int unsigned CntW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CntW-1:0] TimeoutCnt = CntW'(TIMEOUT);

   typedef enum logic [1:0] {StIdle, StGrantA, StGrantB} state_e;

   state_e          state_q, state_d;
   logic            last_b_q, last_b_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            block_a_q, block_a_d;
   logic            block_b_q, block_b_d;
   logic            err_a_q, err_a_d;
   logic            err_b_q, err_b_d;

   logic            req_a, req_b;
   logic            owner_cyc;
   logic            timeout_hit;
   state_e          pick;

   always_comb begin
      req_a     = i_a_cyc & ~block_a_q;
      req_b     = i_b_cyc & ~block_b_q;
      owner_cyc = ((state_q == StGrantA) & i_a_cyc) | ((state_q == StGrantB) & i_b_cyc);
      timeout_hit = (TIMEOUT != 0) && owner_cyc && (cnt_q == TimeoutCnt)
                    && !i_wb_ack && !i_wb_err;

      if (req_a && req_b) begin
         pick = last_b_q ? StGrantA : StGrantB;
      end else if (req_a) begin
         pick = StGrantA;
      end else if (req_b) begin
         pick = StGrantB;
      end else begin
         pick = StIdle;
      end

      state_d = state_q;
      // An abort always passes through idle so the slave sees cyc drop before any handoff.
      unique case (state_q)
         StIdle:   state_d = pick;
         StGrantA: begin
            if (timeout_hit)   state_d = StIdle;
            else if (!i_a_cyc) state_d = pick;
         end
         StGrantB: begin
            if (timeout_hit)   state_d = StIdle;
            else if (!i_b_cyc) state_d = pick;
         end
         default:  state_d = StIdle;
      endcase

      last_b_d = last_b_q;
      if ((state_d == StGrantA) && (state_q != StGrantA)) last_b_d = 1'b0;
      if ((state_d == StGrantB) && (state_q != StGrantB)) last_b_d = 1'b1;

      err_a_d   = timeout_hit & (state_q == StGrantA);
      err_b_d   = timeout_hit & (state_q == StGrantB);
      block_a_d = (block_a_q & i_a_cyc) | err_a_d;
      block_b_d = (block_b_q & i_b_cyc) | err_b_d;

      if ((TIMEOUT == 0) || (state_q == StIdle) || (state_d != state_q) || i_wb_ack || i_wb_err
          || !owner_cyc) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CntW'(1);
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         state_q   <= StIdle;
         last_b_q  <= 1'b1;
         cnt_q     <= '0;
         block_a_q <= 1'b0;
         block_b_q <= 1'b0;
         err_a_q   <= 1'b0;
         err_b_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         last_b_q  <= last_b_d;
         cnt_q     <= cnt_d;
         block_a_q <= block_a_d;
         block_b_q <= block_b_d;
         err_a_q   <= err_a_d;
         err_b_q   <= err_b_d;
      end
   end

   always_comb begin
      o_wb_cyc  = 1'b0;
      o_wb_stb  = 1'b0;
      o_wb_we   = 1'b0;
      o_wb_addr = '0;
      o_wb_data = '0;
      o_wb_sel  = '0;
      o_a_ack   = 1'b0;
      o_a_err   = err_a_q;
      o_a_stall = 1'b1;
      o_b_ack   = 1'b0;
      o_b_err   = err_b_q;
      o_b_stall = 1'b1;

      unique case (state_q)
         StIdle: begin
            o_a_stall = i_a_cyc;
            o_b_stall = i_b_cyc;
         end
         StGrantA: begin
            o_wb_cyc  = i_a_cyc;
            o_wb_stb  = i_a_cyc & i_a_stb;
            o_wb_we   = i_a_we;
            o_wb_addr = i_a_addr;
            o_wb_data = i_a_data;
            o_wb_sel  = i_a_sel;
            o_a_ack   = i_wb_ack;
            o_a_err   = err_a_q | i_wb_err;
            o_a_stall = i_wb_stall;
         end
         StGrantB: begin
            o_wb_cyc  = i_b_cyc;
            o_wb_stb  = i_b_cyc & i_b_stb;
            o_wb_we   = i_b_we;
            o_wb_addr = i_b_addr;
            o_wb_data = i_b_data;
            o_wb_sel  = i_b_sel;
            o_b_ack   = i_wb_ack;
            o_b_err   = err_b_q | i_wb_err;
            o_b_stall = i_wb_stall;
         end
         default: ;
      endcase
   end

   assign o_a_data = i_wb_data;
   assign o_b_data = i_wb_data;

endmodule
